spi_flash_seq: RTL and testbench

Command sequencer directly upstream of the SPI command engine (`spi_cmd`). It turns one host request (sector erase or page program) into the flash command sequence WRITE ENABLE, then the operation, then READ STATUS polling until the write-in-progress bit clears. It owns a 256-byte page buffer and drives the engine's `trigger`/`data_in`/`data_in_count`/`data_out_count`/`quad` inputs, and consumes its `busy`/`data_out` outputs.

---
 rtl/spi_flash_pkg.sv | 34 +++
 rtl/spi_flash_seq_pack.sv | 22 ++
 rtl/spi_flash_seq.sv | 183 ++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash command sequencer.
package spi_flash_pkg;

   localparam logic [7:0] CMD_WREN = 8'h06;
   localparam logic [7:0] CMD_RDSR = 8'h05;
   localparam logic [7:0] CMD_PP   = 8'h02;
   localparam logic [7:0] CMD_SE   = 8'hD8;

   localparam int unsigned MAX_DATA_BYTES = 260;
   localparam int unsigned DATA_W         = MAX_DATA_BYTES * 8;
   localparam int unsigned PAGE_BYTES     = 256;

   typedef enum logic {
      OP_ERASE   = 1'b0,
      OP_PROGRAM = 1'b1
   } op_e;

   // Which command of the request is in flight
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WREN,
      ST_OP,
      ST_POLL,
      ST_DONE
   } state_e;

   // Handshake phase shared by every transaction
   typedef enum logic [1:0] {
      PH_ISSUE,
      PH_WAIT_HI,
      PH_WAIT_LO
   } phase_e;

endpackage

// File: rtl/spi_flash_seq_pack.sv
// Right-aligns opcode, address and payload so the first byte sent sits at bit count*8-1.
module spi_cmd_pack
   import spi_flash_pkg::*;
(
   input  logic [7:0]              opcode,
   input  logic [23:0]             addr,
   input  logic [PAGE_BYTES*8-1:0] payload,
   input  logic [8:0]              count,
   output logic [DATA_W-1:0]       data_out
);

   logic [8:0]  pad_bytes;
   logic [11:0] shamt;

   // Full frame is left-aligned; shifting right drops the unused tail and zero-fills the top
   always_comb begin
      pad_bytes = 9'(MAX_DATA_BYTES) - count;
      shamt     = {pad_bytes, 3'b000};
      data_out  = {opcode, addr, payload} >> shamt;
   end

endmodule

// File: rtl/spi_flash_seq.sv
// Turns one erase/program request into WREN, the operation, then RDSR polling.
module spi_flash_seq
   import spi_flash_pkg::*;
#(
   parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         op,
   input  logic [23:0]  addr,
   input  logic [8:0]   len,
   input  logic         buf_we,
   input  logic [7:0]   buf_addr,
   input  logic [7:0]   buf_data,
   output logic         busy,
   output logic         done,
   output logic         timeout,
   output logic [7:0]   status,
   output logic         cmd_trigger,
   input  logic         cmd_busy,
   output logic [8:0]   cmd_data_in_count,
   output logic         cmd_data_out_count,
   output logic [2079:0] cmd_data_in,
   input  logic [7:0]   cmd_data_out,
   output logic         cmd_quad
);

   state_e state, state_nxt;
   phase_e phase, phase_nxt;

   logic                    accept, fire, xfer_end, poll_last;
   op_e                     op_q;
   logic [23:0]             addr_q;
   logic [8:0]              len_q;
   logic [23:0]             poll_cnt;
   logic [7:0]              page_buf [PAGE_BYTES];
   logic [PAGE_BYTES*8-1:0] payload;
   logic [7:0]              pack_opcode;
   logic [8:0]              pack_count;
   logic                    pack_rd;
   logic [DATA_W-1:0]       pack_data;

   assign cmd_quad  = 1'b0;
   assign poll_last = ({1'b0, poll_cnt} + 25'd1) >= {1'b0, POLL_MAX};

   // Page buffer: host writes land only while no request is running
   always_ff @(posedge clk) begin
      if (buf_we && !busy) page_buf[buf_addr] <= buf_data;
   end

   // Flatten the buffer with byte 0 most significant so it follows the address on the wire
   always_comb begin
      payload = '0;
      for (int unsigned i = 0; i < PAGE_BYTES; i++)
         payload[(PAGE_BYTES-1-i)*8 +: 8] = page_buf[i];
   end

   // Select the next transaction to stage: WREN at accept, the operation after WREN, else RDSR
   always_comb begin
      pack_opcode = CMD_RDSR;
      pack_count  = 9'd1;
      pack_rd     = 1'b1;
      if (state == ST_IDLE) begin
         pack_opcode = CMD_WREN;
         pack_rd     = 1'b0;
      end else if (state == ST_WREN) begin
         pack_rd = 1'b0;
         if (op_q == OP_PROGRAM) begin
            pack_opcode = CMD_PP;
            pack_count  = 9'd4 + len_q;
         end else begin
            pack_opcode = CMD_SE;
            pack_count  = 9'd4;
         end
      end
   end

   spi_cmd_pack u_pack (
      .opcode   (pack_opcode),
      .addr     (addr_q),
      .payload  (payload),
      .count    (pack_count),
      .data_out (pack_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         phase <= PH_ISSUE;
      end else begin
         state <= state_nxt;
         phase <= phase_nxt;
      end
   end

   // Next state and handshake strobes; busy/done decode straight from the state
   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      fire      = 1'b0;
      xfer_end  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = ST_WREN;
               phase_nxt = PH_ISSUE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy = 1'b1;
            case (phase)
               PH_ISSUE: begin
                  if (!cmd_busy) begin
                     fire      = 1'b1;
                     phase_nxt = PH_WAIT_HI;
                  end
               end
               PH_WAIT_HI: begin
                  if (cmd_busy) phase_nxt = PH_WAIT_LO;
               end
               default: begin
                  if (!cmd_busy) begin
                     xfer_end  = 1'b1;
                     phase_nxt = PH_ISSUE;
                     case (state)
                        ST_WREN: state_nxt = ST_OP;
                        ST_OP:   state_nxt = ST_POLL;
                        default: if (!cmd_data_out[0] || poll_last) state_nxt = ST_DONE;
                     endcase
                  end
               end
            endcase
         end
      endcase
   end

   // Request capture, engine command registers, trigger, poll bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_trigger        <= 1'b0;
         cmd_data_in        <= '0;
         cmd_data_in_count  <= '0;
         cmd_data_out_count <= 1'b0;
         status             <= '0;
         timeout            <= 1'b0;
         poll_cnt           <= '0;
         op_q               <= OP_ERASE;
         addr_q             <= '0;
         len_q              <= '0;
      end else begin
         cmd_trigger <= fire;
         if (accept) begin
            op_q     <= op_e'(op);
            addr_q   <= addr;
            len_q    <= (len == 9'd0 || len > 9'd256) ? 9'd256 : len;
            timeout  <= 1'b0;
            poll_cnt <= '0;
         end
         // Staged one cycle ahead of ISSUE; a repeated RDSR reuses what is already loaded
         if (accept || (xfer_end && state != ST_POLL)) begin
            cmd_data_in        <= pack_data;
            cmd_data_in_count  <= pack_count;
            cmd_data_out_count <= pack_rd;
         end
         if (xfer_end && state == ST_POLL) begin
            status   <= cmd_data_out;
            poll_cnt <= poll_cnt + 24'd1;
            if (cmd_data_out[0] && poll_last) timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Randomized bench for spi_flash_seq with a behavioural SPI engine/flash model.
module tb_spi_flash_seq;

   localparam logic [23:0] POLL_MAX_TB = 24'd3;

   logic          clk = 1'b0;
   logic          reset, start, op, buf_we;
   logic [23:0]   addr;
   logic [8:0]    len;
   logic [7:0]    buf_addr, buf_data;
   logic          busy, done, timeout, cmd_trigger, cmd_data_out_count, cmd_quad;
   logic [7:0]    status;
   logic          cmd_busy;
   logic [8:0]    cmd_data_in_count;
   logic [2079:0] cmd_data_in;
   logic [7:0]    cmd_data_out;

   spi_flash_seq #(.POLL_MAX(POLL_MAX_TB)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .len(len),
      .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
      .busy(busy), .done(done), .timeout(timeout), .status(status),
      .cmd_trigger(cmd_trigger), .cmd_busy(cmd_busy),
      .cmd_data_in_count(cmd_data_in_count), .cmd_data_out_count(cmd_data_out_count),
      .cmd_data_in(cmd_data_in), .cmd_data_out(cmd_data_out), .cmd_quad(cmd_quad)
   );

   always #5 clk = ~clk;

   // ---------------- engine + flash model ----------------
   int unsigned   reset_hold = 3;
   logic [7:0]    stat_list [16];
   int unsigned   stat_len = 0, stat_gen = 0;
   logic [7:0]    stuck = 8'h00;
   int unsigned   eng_cnt = 0, eng_idx = 0, eng_gen = 0;
   logic          eng_rd = 1'b0;
   logic [7:0]    eng_ret = 8'h00;
   int unsigned   bad_trig = 0, unstable = 0;
   logic          prev_trig = 1'b0;
   logic [2079:0] prev_din = '0;
   logic [8:0]    tx_cnt [$];
   logic          tx_rd  [$];
   logic [2079:0] tx_dat [$];

   // Engine: busy out of reset, logs each accepted trigger, returns queued status bytes on RDSR
   always @(posedge clk) begin : engine
      int unsigned k;
      prev_din  <= cmd_data_in;
      prev_trig <= cmd_trigger;
      if (!reset && cmd_trigger && (cmd_busy || prev_trig)) bad_trig <= bad_trig + 1;
      if (!reset && cmd_trigger && cmd_data_in !== prev_din) unstable <= unstable + 1;
      if (reset) begin
         cmd_busy     <= 1'b1;
         eng_cnt      <= reset_hold;
         eng_rd       <= 1'b0;
         cmd_data_out <= 8'h00;
      end else if (eng_cnt != 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) begin
            cmd_busy <= 1'b0;
            if (eng_rd) cmd_data_out <= eng_ret;
         end
      end else if (cmd_trigger) begin
         tx_cnt.push_back(cmd_data_in_count);
         tx_rd.push_back(cmd_data_out_count);
         tx_dat.push_back(cmd_data_in);
         cmd_busy <= 1'b1;
         eng_cnt  <= $urandom_range(6, 2);
         eng_rd   <= cmd_data_out_count;
         if (cmd_data_out_count) begin
            k = (eng_gen == stat_gen) ? eng_idx : 0;
            eng_ret <= (k < stat_len) ? stat_list[k] : stuck;
            eng_idx <= k + 1;
            eng_gen <= stat_gen;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0]    tb_buf [256];
   logic [8:0]    exp_cnt [$];
   logic          exp_rd  [$];
   logic [2079:0] exp_dat [$];
   logic [7:0]    exp_status;
   logic          exp_timeout;

   task automatic model_req(input logic o, input logic [23:0] a, input logic [8:0] l);
      logic [2079:0] d;
      logic [7:0]    s;
      int unsigned   n;
      exp_cnt.delete(); exp_rd.delete(); exp_dat.delete();
      exp_cnt.push_back(9'd1); exp_rd.push_back(1'b0); exp_dat.push_back(2080'(8'h06));
      n = (l == 9'd0) ? 256 : int'(l);
      d = 2080'(o ? 8'h02 : 8'hD8);
      for (int j = 0; j < 3; j++) d = (d << 8) | 2080'(8'(a >> (16 - 8*j)));
      if (o) for (int j = 0; j < n; j++) d = (d << 8) | 2080'(tb_buf[j]);
      exp_cnt.push_back(o ? 9'(4 + n) : 9'd4); exp_rd.push_back(1'b0); exp_dat.push_back(d);
      exp_timeout = 1'b0;
      exp_status  = 8'h00;
      for (int p = 0; p < 1000; p++) begin
         s = (p < stat_len) ? stat_list[p] : stuck;
         exp_cnt.push_back(9'd1); exp_rd.push_back(1'b1); exp_dat.push_back(2080'(8'h05));
         exp_status = s;
         if (!s[0]) break;
         if (p + 1 == int'(POLL_MAX_TB)) begin exp_timeout = 1'b1; break; end
      end
   endtask

   // ---------------- drivers ----------------
   int unsigned n_checks = 0, n_fail = 0;
   int unsigned n_done, trig_lat, last_base;
   logic        completed, busy1, timeout1, busy_at_done, junk_en = 1'b0;
   logic        sim_we = 1'b0;
   logic [7:0]  sim_addr, sim_data;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
      buf_we = 1'b1; buf_addr = a; buf_data = d;
      tick();
      buf_we = 1'b0;
      tb_buf[a] = d;
   endtask

   task automatic run_req(input logic o, input logic [23:0] a, input logic [8:0] l, input int unsigned second_at);
      int unsigned n;
      n_done = 0; trig_lat = 0; completed = 1'b0; busy_at_done = 1'b1;
      op = o; addr = a; len = l; start = 1'b1;
      buf_we = sim_we; buf_addr = sim_addr; buf_data = sim_data;
      tick();
      start = 1'b0; buf_we = 1'b0; sim_we = 1'b0;
      busy1 = busy; timeout1 = timeout;
      n = 1;
      while (!completed && n < 4000) begin
         if (cmd_trigger && trig_lat == 0) trig_lat = n;
         if (done) begin n_done++; completed = 1'b1; busy_at_done = busy; end
         start = (second_at != 0 && n == second_at);
         if (start) begin op = ~o; addr = ~a; len = 9'd7; end
         buf_we = junk_en && busy; buf_addr = 8'($urandom); buf_data = 8'($urandom);
         tick();
         n++;
      end
      start = 1'b0; buf_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (done) n_done++;
         tick();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
      n_checks++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h want 00", status); end
      n_checks++; if (cmd_trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger got %b want 0", cmd_trigger); end
      n_checks++; if (cmd_data_in_count !== 9'd0) begin n_fail++; $display("FAIL reset_in_count got %0d want 0", cmd_data_in_count); end
      n_checks++; if (cmd_data_out_count !== 1'b0) begin n_fail++; $display("FAIL reset_out_count got %b want 0", cmd_data_out_count); end
      n_checks++; if (cmd_quad !== 1'b0) begin n_fail++; $display("FAIL reset_quad got %b want 0", cmd_quad); end
      reset = 1'b0;
   endtask

   task automatic test_request(input string name, input logic o, input logic [23:0] a,
                               input logic [8:0] l, input int unsigned second_at);
      logic [2079:0] got, want;
      model_req(o, a, l);
      stat_gen++;
      last_base = tx_cnt.size();
      run_req(o, a, l, second_at);
      n_checks++;
      if (!completed || n_done != 1) begin
         n_fail++; $display("FAIL %s done_pulses got %0d (completed=%b) want 1", name, n_done, completed);
      end
      n_checks++;
      if (tx_cnt.size() - last_base != exp_cnt.size()) begin
         n_fail++; $display("FAIL %s tx_count got %0d want %0d", name, tx_cnt.size() - last_base, exp_cnt.size());
      end else begin
         for (int i = 0; i < exp_cnt.size(); i++) begin
            got = tx_dat[last_base + i]; want = exp_dat[i];
            n_checks++;
            if (tx_cnt[last_base + i] !== exp_cnt[i] || tx_rd[last_base + i] !== exp_rd[i] || got !== want) begin
               n_fail++;
               $display("FAIL %s tx%0d got cnt=%0d rd=%b lo64=%h want cnt=%0d rd=%b lo64=%h", name, i,
                        tx_cnt[last_base + i], tx_rd[last_base + i], got[63:0], exp_cnt[i], exp_rd[i], want[63:0]);
            end
         end
      end
      n_checks++; if (status !== exp_status) begin n_fail++; $display("FAIL %s status got %h want %h", name, status, exp_status); end
      n_checks++; if (timeout !== exp_timeout) begin n_fail++; $display("FAIL %s timeout got %b want %b", name, timeout, exp_timeout); end
      n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start got %b want 1", name, busy1); end
      n_checks++; if (timeout1 !== 1'b0) begin n_fail++; $display("FAIL %s timeout_cleared got %b want 0", name, timeout1); end
      n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL %s busy_with_done got %b want 0", name, busy_at_done); end
      n_checks++; if (bad_trig !== 0) begin n_fail++; $display("FAIL %s trigger_rule got %0d bad want 0", name, bad_trig); end
      n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL %s data_stable got %0d changes want 0", name, unstable); end
   endtask

   task automatic test_engine_hold();
      reset_hold = 10;
      reset = 1'b1; tick(); tick();
      reset = 1'b0; tick(); tick();
      stat_list[0] = 8'h00; stat_len = 1;
      test_request("engine_hold", 1'b0, 24'($urandom), 9'd0, 3);
      n_checks++; if (trig_lat != 9) begin n_fail++; $display("FAIL engine_hold trig_latency got %0d want 9", trig_lat); end
      reset_hold = 3;
   endtask

   task automatic test_erase();
      stat_list[0] = 8'h03; stat_list[1] = 8'h03; stat_list[2] = 8'h00; stat_len = 3;
      test_request("erase", 1'b0, 24'h012345, 9'd0, 0);
      n_checks++; if (trig_lat != 2) begin n_fail++; $display("FAIL erase trig_latency got %0d want 2", trig_lat); end
   endtask

   task automatic test_program();
      logic [2079:0] got;
      write_byte(8'd0, 8'hAA); write_byte(8'd1, 8'hBB); write_byte(8'd2, 8'hCC);
      sim_we = 1'b1; sim_addr = 8'd3; sim_data = 8'hDD; tb_buf[3] = 8'hDD;
      stat_list[0] = 8'h00; stat_len = 1;
      test_request("prog4", 1'b1, 24'h000000, 9'd4, 0);
      if (tx_dat.size() > last_base + 1) begin
         got = tx_dat[last_base + 1];
         n_checks++;
         if (got[63:0] !== 64'h02000000AABBCCDD || tx_cnt[last_base + 1] !== 9'd8) begin
            n_fail++; $display("FAIL prog4_frame got cnt=%0d lo64=%h want cnt=8 lo64=02000000aabbccdd", tx_cnt[last_base + 1], got[63:0]);
         end
      end
      for (int i = 0; i < 256; i++) write_byte(8'(i), 8'($urandom));
      stat_list[0] = 8'h01; stat_list[1] = 8'h00; stat_len = 2;
      test_request("prog256", 1'b1, 24'($urandom), 9'd0, 0);
      if (tx_cnt.size() > last_base + 1) begin
         n_checks++;
         if (tx_cnt[last_base + 1] !== 9'd260) begin
            n_fail++; $display("FAIL prog256_count got %0d want 260", tx_cnt[last_base + 1]);
         end
      end
   endtask

   task automatic test_timeout();
      stat_len = 0; stuck = 8'h01;
      test_request("timeout", 1'b0, 24'($urandom), 9'd0, 0);
      stuck = 8'h00;
   endtask

   task automatic test_random();
      junk_en = 1'b1;
      for (int it = 0; it < 20; it++) begin
         for (int j = 0; j < 8; j++) write_byte(8'($urandom), 8'($urandom));
         stat_len = $urandom_range(4, 1);
         for (int j = 0; j < 16; j++) stat_list[j] = 8'($urandom);
         stuck = 8'($urandom);
         test_request("random", 1'($urandom), 24'($urandom), 9'($urandom_range(256, 0)), 0);
      end
      junk_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int unsigned n;
      stat_list[0] = 8'h82; stat_len = 1;
      test_request("pre_reset", 1'b0, 24'($urandom), 9'd0, 0);
      stat_list[0] = 8'h00; stat_len = 1; stat_gen++;
      last_base = tx_cnt.size();
      op = 1'b1; addr = 24'($urandom); len = 9'd16; start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(tx_cnt.size() == last_base + 2 && cmd_busy) && n < 300) begin tick(); n++; end
      n_checks++;
      if (n >= 300) begin
         n_fail++; $display("FAIL reset_mid wait_op got timeout want op transaction");
      end else begin
         tick();
         reset = 1'b1;
         tick();
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %b want 0", busy); end
         n_checks++; if (cmd_trigger !== 1'b0) begin n_fail++; $display("FAIL reset_mid trigger got %b want 0", cmd_trigger); end
         n_checks++; if (status !== 8'h00) begin n_fail++; $display("FAIL reset_mid status got %h want 00", status); end
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 1'b0; addr = '0; len = '0;
      buf_we = 1'b0; buf_addr = '0; buf_data = '0; sim_addr = '0; sim_data = '0;
      for (int i = 0; i < 256; i++) tb_buf[i] = 8'h00;
      for (int i = 0; i < 16; i++) stat_list[i] = 8'h00;
      test_reset();
      test_engine_hold();
      test_erase();
      test_program();
      test_timeout();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no finish want finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
